// File: rtl/inspecao_lote_seq.sv
// ---------------------------------------------------------------------------
// inspecao_lote_seq
// Clocked lot classifier. On each accepted strobe it counts the active defect
// sensors and classifies the lot as aceito, comprometido or recusado. It then
// drives the 7-segment letter and a timed buzzer. It keeps saturating lot counts
// per category and halts the line after a run of consecutive rejections.
//
// Ports:
//   clk                 system clock
//   reset               synchronous, active-high reset
//   in_sensores         defect sensor vector (1 = defect)
//   in_valido           single-cycle strobe, in_sensores holds a lot
//   in_limpa_alarme     operator clear of the line-halt alarm
//   in_zera_contadores  clear all lot counters
//   lote_aceito/lote_comprometido/lote_recusado  one-hot result of last lot
//   out_valido          one-cycle pulse, new result on outputs
//   seg                 segments {a,b,c,d,e,f,g}, active-high
//   sound_buzzer        buzzer drive
//   alarme_linha        line halted, lots ignored
//   cnt_aceito/cnt_comprometido/cnt_recusado    saturating lot counts
// ---------------------------------------------------------------------------
module inspecao_lote_seq #(
   parameter int N_SENSORES    = 5,
   parameter int ACEITO_MAX    = 0,
   parameter int COMPR_MAX     = 2,
   parameter int CNT_W         = 8,
   parameter int BUZZER_CICLOS = 1000,
   parameter int REJ_SEQ_MAX   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_SENSORES-1:0] in_sensores,
   input  logic                  in_valido,
   input  logic                  in_limpa_alarme,
   input  logic                  in_zera_contadores,
   output logic                  lote_aceito,
   output logic                  lote_comprometido,
   output logic                  lote_recusado,
   output logic                  out_valido,
   output logic [6:0]            seg,
   output logic                  sound_buzzer,
   output logic                  alarme_linha,
   output logic [CNT_W-1:0]      cnt_aceito,
   output logic [CNT_W-1:0]      cnt_comprometido,
   output logic [CNT_W-1:0]      cnt_recusado
);

   localparam int K_W   = $clog2(N_SENSORES + 1);
   localparam int TMR_W = $clog2(BUZZER_CICLOS + 1);
   localparam int REJ_W = $clog2(REJ_SEQ_MAX + 1);

   localparam logic [6:0] SEG_A     = 7'b1110111;
   localparam logic [6:0] SEG_C     = 7'b1001110;
   localparam logic [6:0] SEG_R     = 7'b0000101;
   localparam logic [6:0] SEG_TRACO = 7'b0000001;

   localparam logic [REJ_W-1:0] REJ_LIMITE   = REJ_W'(REJ_SEQ_MAX);
   localparam logic [REJ_W-1:0] REJ_PENULT   = REJ_W'(REJ_SEQ_MAX - 1);
   localparam logic [TMR_W-1:0] TMR_CARGA    = TMR_W'(BUZZER_CICLOS);
   localparam logic [CNT_W-1:0] CNT_SATURADO = {CNT_W{1'b1}};

   typedef enum logic {
      OPERANDO = 1'b0,
      PARADO   = 1'b1
   } estado_t;

   estado_t            r_estado;
   estado_t            w_estado_prox;
   logic               w_aceita;
   logic               w_alarme;
   logic [K_W-1:0]     w_k;
   logic               w_cat_a;
   logic               w_cat_c;
   logic               w_cat_r;

   logic               r_aceito;
   logic               r_comprometido;
   logic               r_recusado;
   logic               r_out_valido;
   logic [6:0]         r_seg;
   logic [TMR_W-1:0]   r_timer;
   logic [REJ_W-1:0]   r_rej;
   logic [CNT_W-1:0]   r_cnt_a;
   logic [CNT_W-1:0]   r_cnt_c;
   logic [CNT_W-1:0]   r_cnt_r;

   // Population count of the sensor vector
   always_comb begin
      w_k = '0;
      for (int i = 0; i < N_SENSORES; i++) begin
         w_k = w_k + K_W'(in_sensores[i]);
      end
   end

   always_comb begin
      w_cat_a = (int'(w_k) <= ACEITO_MAX);
      w_cat_r = (int'(w_k) >  COMPR_MAX);
      w_cat_c = !w_cat_a && !w_cat_r;
   end

   // Next-state logic. While halted, strobes are not accepted, even when they
   // arrive together with the operator clear.
   always_comb begin
      w_estado_prox = r_estado;
      w_aceita      = 1'b0;
      w_alarme      = 1'b0;
      case (r_estado)
         OPERANDO: begin
            w_aceita = in_valido;
            // The rejection that completes the run halts the line on the
            // same edge that registers its result
            if (in_valido && w_cat_r && (r_rej == REJ_PENULT)) begin
               w_estado_prox = PARADO;
            end
         end
         PARADO: begin
            w_alarme = 1'b1;
            if (in_limpa_alarme) begin
               w_estado_prox = OPERANDO;
            end
         end
         default: w_estado_prox = OPERANDO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_estado <= OPERANDO;
      end else begin
         r_estado <= w_estado_prox;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_aceito       <= 1'b0;
         r_comprometido <= 1'b0;
         r_recusado     <= 1'b0;
         r_out_valido   <= 1'b0;
         r_seg          <= SEG_TRACO;
         r_timer        <= '0;
         r_rej          <= '0;
         r_cnt_a        <= '0;
         r_cnt_c        <= '0;
         r_cnt_r        <= '0;
      end else begin
         r_out_valido <= w_aceita;

         // A new rejection restarts the tone even if one is still sounding
         if (w_aceita && w_cat_r) begin
            r_timer <= TMR_CARGA;
         end else if (r_timer != '0) begin
            r_timer <= r_timer - 1'b1;
         end

         // A counter clear overrides the letter and shows '-', even for a lot
         // classified on the same cycle
         if (w_aceita) begin
            r_aceito       <= w_cat_a;
            r_comprometido <= w_cat_c;
            r_recusado     <= w_cat_r;
            if (in_zera_contadores) begin
               r_seg <= SEG_TRACO;
            end else if (w_cat_a) begin
               r_seg <= SEG_A;
            end else if (w_cat_c) begin
               r_seg <= SEG_C;
            end else begin
               r_seg <= SEG_R;
            end
         end else if (in_zera_contadores) begin
            r_seg <= SEG_TRACO;
         end

         if (in_zera_contadores) begin
            r_cnt_a <= '0;
            r_cnt_c <= '0;
            r_cnt_r <= '0;
         end else if (w_aceita) begin
            if (w_cat_a && (r_cnt_a != CNT_SATURADO)) r_cnt_a <= r_cnt_a + 1'b1;
            if (w_cat_c && (r_cnt_c != CNT_SATURADO)) r_cnt_c <= r_cnt_c + 1'b1;
            if (w_cat_r && (r_cnt_r != CNT_SATURADO)) r_cnt_r <= r_cnt_r + 1'b1;
         end

         if ((r_estado == PARADO) && in_limpa_alarme) begin
            r_rej <= '0;
         end else if (w_aceita) begin
            if (!w_cat_r) begin
               r_rej <= '0;
            end else if (r_rej != REJ_LIMITE) begin
               r_rej <= r_rej + 1'b1;
            end
         end
      end
   end

   assign lote_aceito       = r_aceito;
   assign lote_comprometido = r_comprometido;
   assign lote_recusado     = r_recusado;
   assign out_valido        = r_out_valido;
   assign seg               = r_seg;
   assign sound_buzzer      = (r_timer != '0);
   assign alarme_linha      = w_alarme;
   assign cnt_aceito        = r_cnt_a;
   assign cnt_comprometido  = r_cnt_c;
   assign cnt_recusado      = r_cnt_r;

endmodule

// File: tb/tb_inspecao_lote_seq.sv
module tb_inspecao_lote_seq;

   localparam int N      = 5;
   localparam int CW     = 2;
   localparam int BUZZ   = 1000;
   localparam int REJMAX = 3;
   localparam int CMAX   = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  in_sensores;
   logic          in_valido;
   logic          in_limpa_alarme;
   logic          in_zera_contadores;
   logic          lote_aceito;
   logic          lote_comprometido;
   logic          lote_recusado;
   logic          out_valido;
   logic [6:0]    seg;
   logic          sound_buzzer;
   logic          alarme_linha;
   logic [CW-1:0] cnt_aceito;
   logic [CW-1:0] cnt_comprometido;
   logic [CW-1:0] cnt_recusado;

   inspecao_lote_seq #(
      .N_SENSORES    (N),
      .ACEITO_MAX    (0),
      .COMPR_MAX     (2),
      .CNT_W         (CW),
      .BUZZER_CICLOS (BUZZ),
      .REJ_SEQ_MAX   (REJMAX)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .in_sensores        (in_sensores),
      .in_valido          (in_valido),
      .in_limpa_alarme    (in_limpa_alarme),
      .in_zera_contadores (in_zera_contadores),
      .lote_aceito        (lote_aceito),
      .lote_comprometido  (lote_comprometido),
      .lote_recusado      (lote_recusado),
      .out_valido         (out_valido),
      .seg                (seg),
      .sound_buzzer       (sound_buzzer),
      .alarme_linha       (alarme_linha),
      .cnt_aceito         (cnt_aceito),
      .cnt_comprometido   (cnt_comprometido),
      .cnt_recusado       (cnt_recusado)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: category of last lot (-1 none, 0 A, 1 C, 2 r),
   // displayed letter (3 = '-'), counts, reject run, halt flag, tone cycles left
   int m_cat;
   int m_letra;
   int m_cnt [3];
   int m_rej;
   int m_parado;
   int m_buzz;
   int m_ov;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] letra_seg(input int l);
      case (l)
         0:       return 7'b1110111;
         1:       return 7'b1001110;
         2:       return 7'b0000101;
         default: return 7'b0000001;
      endcase
   endfunction

   task automatic modelo_reset();
      m_cat = -1; m_letra = 3; m_rej = 0; m_parado = 0; m_buzz = 0; m_ov = 0;
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
   endtask

   task automatic modelo_passo(input logic [N-1:0] s, input logic v, input logic l,
                               input logic z, input logic r);
      int k;
      int cat;
      int estava_parado;
      if (r) begin
         modelo_reset();
         return;
      end
      estava_parado = m_parado;
      if (m_buzz > 0) m_buzz--;
      m_ov = 0;
      if (v && !estava_parado) begin
         k = $countones(s);
         cat = (k <= 0) ? 0 : (k <= 2) ? 1 : 2;
         m_ov = 1;
         m_cat = cat;
         m_letra = cat;
         if (cat == 2) begin
            m_buzz = BUZZ;
            if (m_rej < REJMAX) m_rej++;
            if (m_rej == REJMAX) m_parado = 1;
         end else begin
            m_rej = 0;
         end
         if (m_cnt[cat] < CMAX) m_cnt[cat]++;
      end
      if (estava_parado && l) begin
         m_parado = 0;
         m_rej = 0;
      end
      if (z) begin
         for (int i = 0; i < 3; i++) m_cnt[i] = 0;
         m_letra = 3;
      end
   endtask

   task automatic verifica();
      chk("lote_aceito",       32'(lote_aceito),       32'(m_cat == 0));
      chk("lote_comprometido", 32'(lote_comprometido), 32'(m_cat == 1));
      chk("lote_recusado",     32'(lote_recusado),     32'(m_cat == 2));
      chk("out_valido",        32'(out_valido),        32'(m_ov));
      chk("seg",               32'(seg),               32'(letra_seg(m_letra)));
      chk("sound_buzzer",      32'(sound_buzzer),      32'(m_buzz != 0));
      chk("alarme_linha",      32'(alarme_linha),      32'(m_parado));
      chk("cnt_aceito",        32'(cnt_aceito),        32'(m_cnt[0]));
      chk("cnt_comprometido",  32'(cnt_comprometido),  32'(m_cnt[1]));
      chk("cnt_recusado",      32'(cnt_recusado),      32'(m_cnt[2]));
   endtask

   // Inputs are applied 1 time unit after an edge, sampled at the next edge,
   // and outputs are compared 1 time unit after that edge.
   task automatic passo(input logic [N-1:0] s, input logic v, input logic l,
                        input logic z, input logic r);
      in_sensores        = s;
      in_valido          = v;
      in_limpa_alarme    = l;
      in_zera_contadores = z;
      reset              = r;
      @(posedge clk);
      modelo_passo(s, v, l, z, r);
      #1;
      verifica();
   endtask

   task automatic lote(input logic [N-1:0] s);
      passo(s, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic ocioso(input int n);
      for (int i = 0; i < n; i++) passo('0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      modelo_reset();
      reset = 1'b1; in_sensores = '0; in_valido = 1'b0;
      in_limpa_alarme = 1'b0; in_zera_contadores = 1'b0;
      passo('0, 1'b0, 1'b0, 1'b0, 1'b1);
      passo('0, 1'b0, 1'b0, 1'b0, 1'b1);
      ocioso(2);

      // aceito, comprometido, recusado with full tone
      lote(5'b00000); ocioso(2);
      lote(5'b00011); ocioso(1);
      lote(5'b10111); ocioso(BUZZ + 5);

      // run of three rejections halts, fourth strobe ignored, operator clear
      lote(5'b00000);
      lote(5'b11111); lote(5'b11100); lote(5'b01111);
      lote(5'b11111); ocioso(3);
      passo('0, 1'b0, 1'b1, 1'b0, 1'b0);
      ocioso(1);
      lote(5'b00001); ocioso(2);

      // aceito breaks the run
      lote(5'b11111); lote(5'b00000); lote(5'b11111); lote(5'b11111); ocioso(2);

      // saturation, then clear together with a strobe
      for (int i = 0; i < 5; i++) lote(5'b00000);
      passo(5'b00011, 1'b1, 1'b0, 1'b1, 1'b0);
      ocioso(2);

      // tone restart, then reset mid-tone
      lote(5'b11111); ocioso(500);
      lote(5'b11111); ocioso(600);
      passo('0, 1'b0, 1'b0, 1'b0, 1'b1);
      ocioso(2);

      // clear alone, operator clear while operating, clear+strobe while halted
      lote(5'b00011);
      passo('0, 1'b0, 1'b0, 1'b1, 1'b0);
      passo('0, 1'b0, 1'b1, 1'b0, 1'b0);
      lote(5'b11111); lote(5'b11111); lote(5'b11111);
      passo(5'b00000, 1'b1, 1'b1, 1'b0, 1'b0);
      ocioso(2);

      // randomized traffic
      for (int c = 0; c < 8000; c++) begin
         logic [N-1:0] s;
         logic v, l, z, r;
         case ($urandom_range(0, 2))
            0:       s = N'($urandom);
            1:       s = 5'b11111 ^ N'(1 << $urandom_range(0, 4));
            default: s = '0;
         endcase
         v = ($urandom_range(0, 99) < 60);
         l = ($urandom_range(0, 99) < 4);
         z = ($urandom_range(0, 99) < 3);
         r = ($urandom_range(0, 999) < 2);
         passo(s, v, l, z, r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
